// File: rtl/mem_pkg.sv
// Shared types and defaults for the arbitrated line memory.
package mem_pkg;

  typedef enum logic {IDLE, WAIT} state_t;

  localparam int DEF_LINE_W  = 256;
  localparam int DEF_DEPTH   = 512;
  localparam int DEF_LATENCY = 10;

  // Line index of a byte address: drop the in-line offset, keep idxw bits.
  function automatic logic [31:0] idx_of(input logic [63:0] addr, input int off, input int idxw);
    logic [63:0] sh;
    sh = addr >> off;
    return 32'(sh & ((64'd1 << idxw) - 64'd1));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin select among requesters; pointer advances past the winner on update.
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 update,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IW-1:0]        idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (int'(ptr) + i) % NUM_PORTS;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (idx == IW'(NUM_PORTS - 1)) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/line_memory_arb.sv
// Line-wide backing store shared by NUM_PORTS requesters with round-robin
// arbitration and a fixed programmable access latency.
module line_memory_arb
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W    = DEF_LINE_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = DEF_LATENCY,
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_PORTS-1:0]        enable_i,
  input  logic [NUM_PORTS-1:0]        write_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
  input  logic [NUM_PORTS*LINE_W-1:0] data_i,
  output logic [NUM_PORTS-1:0]        ack_o,
  output logic [LINE_W-1:0]           data_o,
  output logic                        busy_o,
  output logic [IW-1:0]               grant_o
);

  localparam int OFF  = $clog2(LINE_W / 8);
  localparam int IDXW = $clog2(DEPTH);
  localparam int CW   = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         count;
  logic [ADDR_W-1:0]     addr_lat;
  logic [LINE_W-1:0]     data_lat;
  logic                  write_lat;
  logic [IW-1:0]         port_lat;
  logic [LINE_W-1:0]     mem [DEPTH];
  logic [NUM_PORTS-1:0]  arb_grant;
  logic [IW-1:0]         arb_idx;
  logic                  accept;
  logic                  done;
  logic [IDXW-1:0]       line_idx;

  assign accept   = (state_q == IDLE) && (|enable_i);
  assign done     = (state_q == WAIT) && (count == LAST);
  assign line_idx = IDXW'(idx_of(64'(addr_lat), OFF, IDXW));

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    (enable_i),
    .update (accept),
    .grant  (arb_grant),
    .idx    (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (done)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Control: counter, handshake outputs and read data register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count    <= '0;
      ack_o    <= '0;
      data_o   <= '0;
      busy_o   <= 1'b0;
      grant_o  <= '0;
      port_lat <= '0;
    end else begin
      ack_o <= '0;
      if (accept) begin
        count    <= '0;
        busy_o   <= 1'b1;
        grant_o  <= arb_idx;
        port_lat <= arb_idx;
      end else if (done) begin
        count           <= '0;
        busy_o          <= 1'b0;
        ack_o[port_lat] <= 1'b1;
        if (!write_lat) data_o <= mem[line_idx];
      end else if (state_q == WAIT) begin
        count <= count + CW'(1);
      end
    end
  end

  // Request latch: captured once at acceptance, held through WAIT.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_lat  <= addr_i[arb_idx*ADDR_W +: ADDR_W];
      data_lat  <= data_i[arb_idx*LINE_W +: LINE_W];
      write_lat <= |(write_i & arb_grant);
    end
  end

  // A reset on the completion edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && done && write_lat) mem[line_idx] <= data_lat;
  end

endmodule

// File: tb/tb_line_memory_arb.sv
// Randomised and directed bench for line_memory_arb with a transaction-level reference model.
module tb_line_memory_arb;

  localparam int NP  = 2;
  localparam int LW  = 256;
  localparam int LAT = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   en, wr;
  logic [NP*32-1:0] addr;
  logic [NP*LW-1:0] din;
  logic [NP-1:0]   ack_o;
  logic [LW-1:0]   data_o;
  logic            busy_o;
  logic [0:0]      grant_o;

  logic [NP-1:0]    en1, wr1, ack1;
  logic [NP*32-1:0] addr1;
  logic [NP*LW-1:0] din1;
  logic [LW-1:0]    data1;
  logic             busy1;
  logic [0:0]       grant1;

  always #5 clk = ~clk;

  line_memory_arb #(.NUM_PORTS(NP), .LINE_W(LW), .DEPTH(512), .ADDR_W(32), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr), .addr_i(addr), .data_i(din),
    .ack_o(ack_o), .data_o(data_o), .busy_o(busy_o), .grant_o(grant_o)
  );

  line_memory_arb #(.NUM_PORTS(NP), .LINE_W(LW), .DEPTH(512), .ADDR_W(32), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(wr1), .addr_i(addr1), .data_i(din1),
    .ack_o(ack1), .data_o(data1), .busy_o(busy1), .grant_o(grant1)
  );

  int total = 0;
  int fails = 0;

  // Reference model: one pending transaction with a countdown to its ack.
  bit            m_busy = 0;
  int            m_rem = 0, m_port = 0, m_idx = 0, m_grant = 0, m_ptr = 0;
  bit            m_wr = 0;
  bit            m_dknown = 1;
  logic [LW-1:0] m_data = '0, m_dout = '0;
  logic [NP-1:0] m_ack = '0;
  logic [LW-1:0] mmem [int];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int  p;
    bit  found;
    p = 0;
    found = 0;
    if (rst) begin
      m_busy = 0; m_ack = '0; m_dout = '0; m_dknown = 1; m_grant = 0; m_ptr = 0;
    end else begin
      m_ack = '0;
      if (!m_busy) begin
        if (en != '0) begin
          for (int k = 0; k < NP; k++) begin
            if (!found && en[(m_ptr + k) % NP]) begin
              found = 1;
              p = (m_ptr + k) % NP;
            end
          end
          m_port = p; m_wr = wr[p]; m_data = din[p*LW +: LW];
          m_idx = int'((addr[p*32 +: 32] >> 5) & 32'h1FF);
          m_rem = LAT; m_busy = 1; m_grant = p; m_ptr = (p + 1) % NP;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_wr) mmem[m_idx] = m_data;
          else if (mmem.exists(m_idx)) begin m_dout = mmem[m_idx]; m_dknown = 1; end
          else m_dknown = 0;
          m_ack[m_port] = 1'b1;
          m_busy = 0;
        end
      end
    end
    @(posedge clk); #1;
    chk("ack", LW'(ack_o), LW'(m_ack));
    chk("busy", LW'(busy_o), LW'(m_busy));
    chk("grant", LW'(grant_o), LW'(m_grant));
    if (m_dknown) chk("data", data_o, m_dout);
    for (int q = 0; q < NP; q++) if (ack_o[q]) en[q] = 1'b0;
  endtask

  task automatic req(input int p, input bit w, input logic [31:0] a, input logic [LW-1:0] d);
    en[p] = 1'b1; wr[p] = w; addr[p*32 +: 32] = a; din[p*LW +: LW] = d;
  endtask

  task automatic serve(input int budget);
    int n = 0;
    while ((en != '0 || m_busy) && n < budget) begin
      tick();
      n++;
    end
    total++;
    assert (n < budget)
    else begin
      fails++;
      $error("FAIL timeout cycles=%0d limit=%0d", n, budget);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  logic [LW-1:0] v, old5;
  logic [31:0]   a;
  int            lines [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 16};

  initial begin
    rst = 1'b1; en = '0; wr = '0; addr = '0; din = '0;
    en1 = '0; wr1 = '0; addr1 = '0; din1 = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Preload the working set of lines through the write path.
    for (int i = 0; i < 9; i++) begin
      v = (lines[i] == 1) ? {4{64'h8888_9999_AAAA_BBBB}} : rnd_line();
      req(i % NP, 1'b1, 32'(lines[i]) << 5, v);
      serve(40);
    end
    old5 = mmem[5];

    // Reset while idle, then confirm line 0 survived.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    req(0, 1'b0, 32'h0, '0);
    serve(40);

    // Single read of line 1 from port 0.
    req(0, 1'b0, 32'h20, '0);
    serve(40);
    chk("read_line1", data_o, {4{64'h8888_9999_AAAA_BBBB}});

    // Port 1 write then read of line 2.
    req(1, 1'b1, 32'h40, {8{32'hDEAD_BEEF}});
    serve(40);
    req(1, 1'b0, 32'h40, '0);
    serve(40);
    chk("wr_rd_line2", data_o, {8{32'hDEAD_BEEF}});

    // Contention, twice in a row.
    for (int r = 0; r < 2; r++) begin
      req(0, 1'b0, 32'h60, '0);
      req(1, 1'b0, 32'h80, '0);
      serve(80);
    end

    // Alias: 0x4200 lands on line 16; read back via 0x21F.
    v = rnd_line();
    req(0, 1'b1, 32'h4200, v);
    serve(40);
    req(1, 1'b0, 32'h21F, '0);
    serve(40);
    chk("alias_line16", data_o, v);

    // Reset at count 5 of a write to line 5 aborts it.
    req(0, 1'b1, 32'hA0, ~old5);
    repeat (6) tick();
    rst = 1'b1; en = '0;
    tick();
    rst = 1'b0;
    req(0, 1'b0, 32'hA0, '0);
    serve(40);
    chk("abort_line5", data_o, old5);

    // Randomised traffic over the working set, with aliasing bits.
    for (int t = 0; t < 30; t++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 1) == 1 || p == NP - 1 && en == '0) begin
          a = ($urandom & 32'hFFFF_C000) | (32'(lines[$urandom_range(0, 8)]) << 5)
              | 32'($urandom_range(0, 31));
          req(p, 1'($urandom_range(0, 1)), a, rnd_line());
        end
      end
      serve(80);
    end

    // LATENCY=1 instance: ack on the edge after acceptance.
    v = rnd_line();
    en1[0] = 1'b1; wr1[0] = 1'b1; addr1[31:0] = 32'h60; din1[LW-1:0] = v;
    @(posedge clk); #1;
    chk("l1_busy", LW'(busy1), LW'(1));
    chk("l1_ack_wait", LW'(ack1), LW'(0));
    @(posedge clk); #1;
    chk("l1_ack_wr", LW'(ack1), LW'(2'b01));
    chk("l1_idle", LW'(busy1), LW'(0));
    en1 = '0;
    @(posedge clk); #1;
    chk("l1_ack_drop", LW'(ack1), LW'(0));
    en1[1] = 1'b1; wr1[1] = 1'b0; addr1[63:32] = 32'h60;
    @(posedge clk); #1;
    chk("l1_grant", LW'(grant1), LW'(1));
    @(posedge clk); #1;
    chk("l1_ack_rd", LW'(ack1), LW'(2'b10));
    chk("l1_data", data1, v);
    en1 = '0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
